fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage plus IF/ID pipeline register for the 5-stage RV32I core.
//  Owns PCF and issues one instruction-memory request at a time (valid/ready request, valid response).
//  Consumes StallF/StallD/FlushD from the hazard unit and PCSrcE/PCTargetE from EX.
//  Delivers InstrD/PCD/PCPlus4D/ValidD to decode, and inserts NOP bubbles when memory is slow.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PCF value after reset
//  NOP_INSTR 32'h0000_0013  bubble encoding (addi x0,x0,0)
// PORTS
//  clk            in   1   single clock; all state on rising edge
//  reset          in   1   synchronous, active-high
//  StallF         in   1   hold PCF (no sequential advance)
//  StallD         in   1   hold IF/ID contents
//  FlushD         in   1   clear IF/ID to bubble
//  PCSrcE         in   1   redirect taken in EX
//  PCTargetE      in   32  redirect target
//  imem_req_valid out  1   request valid
//  imem_req_ready in   1   memory accepts request
//  imem_addr      out  32  request address (= PCF)
//  imem_rsp_valid in   1   response valid, >=1 cycle after accept
//  imem_rsp_data  in   32  instruction word
//  InstrD         out  32  decode instruction
//  PCD            out  32  PC of InstrD
//  PCPlus4D       out  32  PCD+4
//  ValidD         out  1   0 = bubble
// BEHAVIOUR
//  Reset: PCF=RESET_PC, state=S_REQ, buffer empty, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, imem_req_valid=0 in the reset cycle.
//  At most one request is outstanding. Memory returns responses in order, one per accepted request.
//  States:
//   S_REQ: imem_req_valid=1, addr=PCF. Accept (valid&ready) -> S_WAIT.
//          PCSrcE with accept -> S_DROP. PCSrcE without accept -> stay in S_REQ.
//   S_WAIT: rsp_valid -> capture {data,PCF} in a 1-entry buffer -> S_HOLD.
//           PCSrcE with no rsp -> S_DROP. PCSrcE with rsp -> discard rsp, go to S_REQ.
//   S_HOLD: the buffered instruction is available. Deliver when !StallD && !StallF, then PCF<=PCF+4 -> S_REQ.
//   S_DROP: discard the next rsp_valid, then -> S_REQ. PCSrcE here only reloads PCF.
//  Bypass: in S_WAIT, a rsp with !StallD && !StallF delivers directly the same cycle and skips S_HOLD.
//  Redirect: PCSrcE always sets PCF<=PCTargetE next cycle, clears the buffer, and takes precedence over delivery and increment.
//  IF/ID priority, per cycle:
//   1. reset or FlushD: bubble.
//   2. StallD: hold.
//   3. Deliver: {instr, pc, pc+4, ValidD=1}.
//   4. Otherwise: bubble (NOP_INSTR, ValidD=0; PCD/PCPlus4D keep their previous values).
//  PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 0. Misaligned targets are passed through unchanged.
//  Throughput: 1 instruction per 2 cycles with 1-cycle memory; 1 instruction per (latency+1) cycles in general.
//  Reset in any state returns to reset values. A response arriving later is ignored only if state is S_DROP; the bench must not return a pre-reset response after reset.
// STRUCTURE
//  core_pkg: fetch_state_t enum {S_REQ,S_WAIT,S_HOLD,S_DROP}; NOP_INSTR; XLEN=32.
//  Sub-module if_id_reg: IF/ID flops with reset/flush/stall/load priority as above.
//  fetch_stage: FSM, PCF, and the response buffer.
// TESTING
//  1. Reset, ready=1, 1-cycle memory, no stalls -> ValidD pulses every 2nd cycle; PCD=0,4,8,...; bubble cycles show 32'h13.
//  2. StallD=StallF=1 for 3 cycles while S_HOLD -> IF/ID frozen, PCF frozen, no new request; release -> buffered instr delivered next edge.
//  3. PCSrcE=1, PCTargetE=0x100 while S_WAIT, rsp 2 cycles later -> that rsp dropped; next request addr=0x100; PCD=0x100 with ValidD=1.
//  4. PCSrcE=1 in the same cycle as rsp_valid -> rsp discarded, no S_DROP; next request to target; FlushD makes ValidD=0.
//  5. imem_req_ready=0 for 4 cycles -> imem_addr stable, req_valid held, ValidD=0 throughout.
//  6. reset asserted mid-S_WAIT -> next cycle all outputs at reset values; first request to RESET_PC; PCF 0xFFFFFFFC delivers then wraps to 0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and constants for the RV32I core front end.
package core_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } fetch_state_t;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. One-cycle latency.
// Priority: reset/flush -> bubble, stall -> hold, load -> capture, else bubble.
module if_id_reg import core_pkg::*; #(
  parameter logic [XLEN-1:0] NOP = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            stall,
  input  logic            load,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            valid_o
);

  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
  logic            valid_q, valid_d;

  // A bubble only rewrites the instruction and valid bit; the PCs keep their last value.
  always_comb begin
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (flush) begin
      instr_d = NOP;
      valid_d = 1'b0;
    end else if (!stall) begin
      if (load) begin
        instr_d    = instr_i;
        pc_d       = pc_i;
        pc_plus4_d = pc_i + 32'd4;
        valid_d    = 1'b1;
      end else begin
        instr_d = NOP;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q    <= NOP;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PCF, single-outstanding imem request FSM, 1-entry response buffer, IF/ID register.
// Delivers one instruction per (mem latency + 1) cycles; StallF/StallD park a response in the buffer.
module fetch_stage import core_pkg::*; #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pcf_q, pcf_d;
  logic [31:0]  buf_q, buf_d;
  logic         req_active;
  logic         deliver;
  logic [31:0]  deliver_instr;
  logic         can_advance;

  assign can_advance = !StallD && !StallF;

  always_comb begin
    state_d       = state_q;
    pcf_d         = pcf_q;
    buf_d         = buf_q;
    req_active    = 1'b0;
    deliver       = 1'b0;
    deliver_instr = buf_q;
    case (state_q)
      S_REQ: begin
        req_active = 1'b1;
        if (imem_req_ready) state_d = PCSrcE ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (PCSrcE) begin
          state_d = imem_rsp_valid ? S_REQ : S_DROP;
        end else if (imem_rsp_valid) begin
          if (can_advance) begin
            deliver       = 1'b1;
            deliver_instr = imem_rsp_data;
            state_d       = S_REQ;
          end else begin
            buf_d   = imem_rsp_data;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (PCSrcE) begin
          buf_d   = NOP_INSTR;
          state_d = S_REQ;
        end else if (can_advance) begin
          deliver = 1'b1;
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        if (imem_rsp_valid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
    if (deliver) pcf_d = pcf_q + 32'd4;
    // Redirect wins over sequential advance.
    if (PCSrcE) pcf_d = PCTargetE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_REQ;
      pcf_q   <= RESET_PC;
      buf_q   <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pcf_q   <= pcf_d;
      buf_q   <= buf_d;
    end
  end

  assign imem_req_valid = req_active && !reset;
  assign imem_addr      = pcf_q;

  if_id_reg #(.NOP(NOP_INSTR)) u_if_id (
    .clk       (clk),
    .reset     (reset),
    .flush     (FlushD),
    .stall     (StallD),
    .load      (deliver),
    .instr_i   (deliver_instr),
    .pc_i      (pcf_q),
    .instr_o   (InstrD),
    .pc_o      (PCD),
    .pc_plus4_o(PCPlus4D),
    .valid_o   (ValidD)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then randomized traffic, checked against an in-order PC stream model.
module tb_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  int n_pass  = 0;
  int n_total = 0;
  int n_deliv = 0;

  // Memory model: fixed latency per request, one outstanding, in order.
  int          lat        = 1;
  bit          ready_low  = 1'b0;
  bit          rand_ready = 1'b0;
  bit          pend       = 1'b0;
  int          cnt        = 0;
  logic [31:0] paddr      = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0003;
  endfunction

  initial begin
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      if (reset) begin
        pend = 1'b0;
      end else if (pend) begin
        if (cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(paddr);
          pend = 1'b0;
        end else begin
          cnt--;
        end
      end
      imem_req_ready = ready_low ? 1'b0 : (rand_ready ? ($urandom_range(3) != 0) : 1'b1);
      if (imem_req_valid && imem_req_ready && !reset) begin
        pend  = 1'b1;
        paddr = imem_addr;
        cnt   = lat - 1;
      end
    end
  end

  // Reference: decode sees an in-order stream PC, PC+4, ... restarted at each redirect target.
  logic [31:0] exp_pc = RESET_PC;
  bit          p_reset, p_stalld, p_flush, p_redir;
  logic [31:0] p_target;
  bit          delivered;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    p_reset  = reset;
    p_stalld = StallD;
    p_flush  = FlushD;
    p_redir  = PCSrcE;
    p_target = PCTargetE;
    @(negedge clk);
    delivered = 1'b0;
    if (p_reset) begin
      exp_pc = RESET_PC;
    end else begin
      if (p_flush) check("flush_valid", 32'(ValidD), 32'd0);
      if (p_redir) check("redir_no_deliv", 32'(ValidD && !p_stalld), 32'd0);
      if (ValidD && !p_stalld && !p_flush) begin
        delivered = 1'b1;
        n_deliv++;
        check("deliv_pc", PCD, exp_pc);
        check("deliv_instr", InstrD, mem_word(exp_pc));
        check("deliv_pc4", PCPlus4D, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
      end
      if (!ValidD) check("bubble_instr", InstrD, NOP);
      if (p_redir) exp_pc = p_target;
    end
  endtask

  task automatic wait_deliv(input string tag, input int max_cycles);
    int i;
    i = 0;
    delivered = 1'b0;
    while (!delivered && i < max_cycles) begin
      tick();
      i++;
    end
    check(tag, 32'(delivered), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_validd"}, 32'(ValidD), 32'd0);
    check({tag, "_instrd"}, InstrD, NOP);
    check({tag, "_pcd"}, PCD, 32'd0);
    check({tag, "_pcplus4d"}, PCPlus4D, 32'd0);
    check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] held_pc;
    reset = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    PCSrcE = 1'b0; PCTargetE = '0;

    // Reset values
    tick();
    tick();
    check_reset_outputs("rst");

    // 1: 1-cycle memory, no stalls -> ValidD every second cycle
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t1_valid_pattern", 32'(ValidD), 32'(i % 2 == 1));
    end

    // 2: stall both stages while a response is buffered
    held_pc = exp_pc - 32'd4;
    StallF = 1'b1; StallD = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t2_hold_valid", 32'(ValidD), 32'd1);
      check("t2_hold_pcd", PCD, held_pc);
      check("t2_hold_instr", InstrD, mem_word(held_pc));
      check("t2_no_req", 32'(imem_req_valid), 32'd0);
      check("t2_pcf_frozen", imem_addr, held_pc + 32'd4);
    end
    StallF = 1'b0; StallD = 1'b0;
    tick();
    check("t2_release_valid", 32'(ValidD), 32'd1);
    check("t2_release_pcd", PCD, held_pc + 32'd4);

    // 3: redirect while waiting; late response must be dropped
    lat = 3;
    tick();
    check("t3_waiting", 32'(imem_req_valid), 32'd0);
    PCSrcE = 1'b1; PCTargetE = 32'h0000_0100;
    tick();
    PCSrcE = 1'b0;
    wait_deliv("t3_timeout", 20);
    check("t3_pcd", PCD, 32'h0000_0100);
    check("t3_req_addr", paddr, 32'h0000_0100);

    // 4: redirect coincident with the response, plus FlushD
    lat = 1;
    tick();
    PCSrcE = 1'b1; PCTargetE = 32'h0000_0200; FlushD = 1'b1;
    tick();
    PCSrcE = 1'b0; FlushD = 1'b0;
    check("t4_flush_valid", 32'(ValidD), 32'd0);
    check("t4_req_now", 32'(imem_req_valid), 32'd1);
    check("t4_req_addr", imem_addr, 32'h0000_0200);
    wait_deliv("t4_timeout", 10);
    check("t4_pcd", PCD, 32'h0000_0200);

    // 5: memory not ready for four cycles
    ready_low = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t5_req_held", 32'(imem_req_valid), 32'd1);
      check("t5_addr_stable", imem_addr, exp_pc);
      check("t5_no_valid", 32'(ValidD), 32'd0);
    end
    ready_low = 1'b0;
    wait_deliv("t5_timeout", 10);

    // 6: reset mid-wait, then wrap around the top of the address space
    lat = 4;
    tick();
    reset = 1'b1;
    tick();
    check_reset_outputs("t6_rst");
    reset = 1'b0;
    lat = 1;
    tick();
    check("t6_first_req", paddr, RESET_PC);
    wait_deliv("t6_first_timeout", 10);
    check("t6_first_pcd", PCD, RESET_PC);
    PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFF8;
    tick();
    PCSrcE = 1'b0;
    wait_deliv("t6_a_timeout", 10);
    wait_deliv("t6_b_timeout", 10);
    check("t6_top_pcd", PCD, 32'hFFFF_FFFC);
    check("t6_top_pc4_wrap", PCPlus4D, 32'h0000_0000);
    wait_deliv("t6_c_timeout", 10);
    check("t6_wrap_pcd", PCD, 32'h0000_0000);

    // Misaligned target passes through unchanged
    PCSrcE = 1'b1; PCTargetE = 32'h0000_0103;
    tick();
    PCSrcE = 1'b0;
    wait_deliv("mis_timeout", 10);
    check("mis_pcd", PCD, 32'h0000_0103);
    check("mis_pc4", PCPlus4D, 32'h0000_0107);

    // Randomized traffic against the stream model
    n_deliv = 0;
    rand_ready = 1'b1;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(15) == 0) lat = int'($urandom_range(4, 1));
      StallD    = ($urandom_range(3) == 0);
      StallF    = ($urandom_range(4) == 0);
      PCSrcE    = ($urandom_range(19) == 0);
      PCTargetE = ($urandom_range(9) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      tick();
    end
    StallD = 1'b0; StallF = 1'b0; PCSrcE = 1'b0;
    rand_ready = 1'b0;
    check("rand_progress", 32'(n_deliv >= 30), 32'd1);
    wait_deliv("rand_drain_timeout", 20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
